// File: rtl/rst_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rst_seq_pkg
// Brief    : Shared state, reset-cause and reset-level constants for rst_seq.
// Revision : 1.0
// ============================================================================
package rst_seq_pkg;

    typedef logic [2:0] state_t;
    typedef logic [1:0] cause_t;

    localparam logic [2:0] HOLD      = 3'd0;
    localparam logic [2:0] REL_BUS   = 3'd1;
    localparam logic [2:0] REL_IO    = 3'd2;
    localparam logic [2:0] RUN       = 3'd3;
    localparam logic [2:0] SOFT_HOLD = 3'd4;

    localparam cause_t CAUSE_HARD = 2'b00;
    localparam cause_t CAUSE_SOFT = 2'b01;
    localparam cause_t CAUSE_WDT  = 2'b10;

    localparam logic RST_ASSERT   = 1'b0;
    localparam logic RST_DEASSERT = 1'b1;

endpackage
`default_nettype wire

// File: rtl/rst_seq_reset_sync.sv
`default_nettype none
// ============================================================================
// Module   : reset_sync
// Brief    : 2-flop asynchronous-assert / synchronous-release reset synchronizer.
// Revision : 1.0
// ============================================================================
module reset_sync
    import rst_seq_pkg::*;
(
    input  logic clk,
    input  logic reset,
    output logic rst_sync_n
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            meta_q <= RST_ASSERT;
            sync_q <= RST_ASSERT;
        end else begin
            meta_q <= RST_DEASSERT;
            sync_q <= meta_q;
        end
    end

    assign rst_sync_n = sync_q;

endmodule
`default_nettype wire

// File: rtl/rst_seq.sv
`default_nettype none
// ============================================================================
// Module   : rst_seq
// Brief    : Staged bus/IO/CPU reset sequencer with soft and watchdog reset.
// Revision : 1.0
// ============================================================================
module rst_seq
    import rst_seq_pkg::*;
#(
    parameter int HOLD_CYCLES = 16,
    parameter int STAGE_GAP   = 4,
    parameter int CNT_W       = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       soft_rst_req,
    input  logic       wdt_expire,
    output logic       bus_reset,
    output logic       io_reset,
    output logic       cpu_reset,
    output logic       ready,
    output logic [1:0] rst_cause
);

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(STAGE_GAP - 1);

    logic             rst_sync_n;
    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             bus_q, bus_d;
    logic             io_q, io_d;
    logic             cpu_q, cpu_d;
    logic             ready_q, ready_d;
    cause_t           cause_q, cause_d;
    logic             req;

    reset_sync u_reset_sync (
        .clk        (clk),
        .reset      (reset),
        .rst_sync_n (rst_sync_n)
    );

    assign req = soft_rst_req | wdt_expire;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bus_d   = bus_q;
        io_d    = io_q;
        cpu_d   = cpu_q;
        ready_d = ready_q;
        cause_d = cause_q;
        case (state_q)
            HOLD: begin
                if (cnt_q == HOLD_LAST) begin
                    cnt_d   = '0;
                    state_d = REL_BUS;
                    bus_d   = RST_DEASSERT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            REL_BUS: begin
                if (cnt_q == GAP_LAST) begin
                    cnt_d   = '0;
                    state_d = REL_IO;
                    io_d    = RST_DEASSERT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            REL_IO: begin
                if (cnt_q == GAP_LAST) begin
                    cnt_d   = '0;
                    state_d = RUN;
                    cpu_d   = RST_DEASSERT;
                    ready_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RUN: begin
                // Bus domain stays out of reset across soft/watchdog resets.
                if (req) begin
                    cnt_d   = '0;
                    state_d = SOFT_HOLD;
                    io_d    = RST_ASSERT;
                    cpu_d   = RST_ASSERT;
                    ready_d = 1'b0;
                    cause_d = wdt_expire ? CAUSE_WDT : CAUSE_SOFT;
                end
            end
            SOFT_HOLD: begin
                if (cnt_q == HOLD_LAST) begin
                    cnt_d   = '0;
                    state_d = REL_IO;
                    io_d    = RST_DEASSERT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = HOLD;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            state_q <= HOLD;
            cnt_q   <= '0;
            bus_q   <= RST_ASSERT;
            io_q    <= RST_ASSERT;
            cpu_q   <= RST_ASSERT;
            ready_q <= 1'b0;
            cause_q <= CAUSE_HARD;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bus_q   <= bus_d;
            io_q    <= io_d;
            cpu_q   <= cpu_d;
            ready_q <= ready_d;
            cause_q <= cause_d;
        end
    end

    assign bus_reset = bus_q;
    assign io_reset  = io_q;
    assign cpu_reset = cpu_q;
    assign ready     = ready_q;
    assign rst_cause = cause_q;

endmodule
`default_nettype wire

// File: tb/tb_rst_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_rst_seq
// Brief    : Scoreboard bench for rst_seq using an edge-time reference model.
// Revision : 1.0
// ============================================================================
module tb_rst_seq;

    localparam int H = 16;
    localparam int G = 4;

    typedef struct packed {
        logic       bus;
        logic       io;
        logic       cpu;
        logic       rdy;
        logic [1:0] cause;
        int         edge_n;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       soft_rst_req = 1'b0;
    logic       wdt_expire = 1'b0;
    logic       bus_reset, io_reset, cpu_reset, ready;
    logic [1:0] rst_cause;

    int checks = 0;
    int failures = 0;

    // Reference model: absolute edge numbers at which each domain is released.
    int         e_n;
    int         bus_e, io_e, cpu_e;
    logic [1:0] m_cause;
    exp_t       exp_q[$];

    rst_seq #(.HOLD_CYCLES(H), .STAGE_GAP(G), .CNT_W(8)) dut (
        .clk          (clk),
        .reset        (reset),
        .soft_rst_req (soft_rst_req),
        .wdt_expire   (wdt_expire),
        .bus_reset    (bus_reset),
        .io_reset     (io_reset),
        .cpu_reset    (cpu_reset),
        .ready        (ready),
        .rst_cause    (rst_cause)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int ed, input logic [1:0] got, input logic [1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s edge=%0d got=%b exp=%b", nm, ed, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t x;
            x = exp_q.pop_front();
            chk("bus_reset", x.edge_n, {1'b0, bus_reset}, {1'b0, x.bus});
            chk("io_reset",  x.edge_n, {1'b0, io_reset},  {1'b0, x.io});
            chk("cpu_reset", x.edge_n, {1'b0, cpu_reset}, {1'b0, x.cpu});
            chk("ready",     x.edge_n, {1'b0, ready},     {1'b0, x.rdy});
            chk("rst_cause", x.edge_n, rst_cause,         x.cause);
        end
    end

    task automatic check_all_low(input string nm);
        chk({nm, "_bus"},   0, {1'b0, bus_reset}, 2'b00);
        chk({nm, "_io"},    0, {1'b0, io_reset},  2'b00);
        chk({nm, "_cpu"},   0, {1'b0, cpu_reset}, 2'b00);
        chk({nm, "_ready"}, 0, {1'b0, ready},     2'b00);
        chk({nm, "_cause"}, 0, rst_cause,         2'b00);
    endtask

    task automatic model_release();
        e_n     = 0;
        bus_e   = 2 + H;
        io_e    = 2 + H + G;
        cpu_e   = 2 + H + 2 * G;
        m_cause = 2'b00;
    endtask

    // Drives inputs for the next edge, then models and enqueues its result.
    task automatic step(input logic sr, input logic wd);
        exp_t x;
        soft_rst_req = sr;
        wdt_expire   = wd;
        @(posedge clk);
        e_n++;
        if ((sr || wd) && e_n > cpu_e) begin
            io_e    = e_n + H;
            cpu_e   = e_n + H + G;
            m_cause = wd ? 2'b10 : 2'b01;
        end
        x.bus    = (e_n >= bus_e);
        x.io     = (e_n >= io_e);
        x.cpu    = (e_n >= cpu_e);
        x.rdy    = (e_n >= cpu_e);
        x.cause  = m_cause;
        x.edge_n = e_n;
        exp_q.push_back(x);
        #1;
        soft_rst_req = 1'b0;
        wdt_expire   = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0);
    endtask

    task automatic wait_run();
        for (int i = 0; i < 100 && e_n <= cpu_e; i++) step(1'b0, 1'b0);
    endtask

    // Drops reset mid-period; hold==0 gives a sub-period glitch.
    task automatic hard_reset(input int hold);
        soft_rst_req = 1'b0;
        wdt_expire   = 1'b0;
        @(negedge clk);
        #1;
        reset = 1'b0;
        #1;
        check_all_low("async");
        if (hold == 0) begin
            #1;
        end else begin
            repeat (hold) @(posedge clk);
            #1;
            check_all_low("held");
            #2;
        end
        reset = 1'b1;
        model_release();
    endtask

    initial begin
        model_release();
        hard_reset(10);

        // Power-up with requests that must be ignored mid-sequence.
        for (int i = 0; i < 40; i++) begin
            step(1'b0, (e_n + 1) == 20);
            if (e_n == 23) step(1'b1, 1'b0);
        end

        wait_run();
        step(1'b1, 1'b0);
        idle(4);
        step(1'b1, 1'b0);
        idle(12);
        step(1'b0, 1'b1);
        idle(8);

        wait_run();
        step(1'b1, 1'b1);
        idle(25);

        wait_run();
        step(1'b0, 1'b1);
        idle(5);
        hard_reset(3);
        idle(30);

        hard_reset(0);
        idle(30);

        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(399) == 0) hard_reset(int'($urandom_range(3)));
            step($urandom_range(11) == 0, $urandom_range(11) == 0);
        end

        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain got=%0d exp=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
